multi_pulse_gen: RTL
====================

MULTI_PULSE_GEN -- requirements
Module: multi_pulse_gen

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent waveform channels (1..16).
REQ-002 Parameter CNT_W, default 16, width of each phase-length field, in clk_in cycles.
REQ-003 Parameter REP_W, default 8, width of each repeat-count field.
REQ-004 Port clk_in  input  1  single clock (10 MHz nominal); all logic on posedge.
REQ-005 Port rst  input  1  reset; synchronous, active-high.
REQ-006 Port start  input  NUM_CH  per-channel trigger; rising edge (0 then 1 on consecutive samples) launches a burst.
REQ-007 Port abort  input  NUM_CH  per-channel level; terminates the burst.
REQ-008 Port len_lo1  input  NUM_CH*CNT_W  leading-low length per channel; ch i at [i*CNT_W +: CNT_W].
REQ-009 Port len_hi  input  NUM_CH*CNT_W  high length per channel.
REQ-010 Port len_lo2  input  NUM_CH*CNT_W  trailing-low length per channel.
REQ-011 Port rep_cnt  input  NUM_CH*REP_W  bursts per trigger; value 0 means 1.
REQ-012 Port wave_out  output  NUM_CH  waveform level.
REQ-013 Port wave_oe  output  NUM_CH  output enable; 0 means the pin is released (top level tri-states it).
REQ-014 Port busy  output  NUM_CH  channel not IDLE.
REQ-015 Port done  output  NUM_CH  one-cycle pulse on normal burst-sequence completion.

Function
REQ-016 Each channel SHALL run an FSM with states IDLE, LO1, HI, LO2.
REQ-017 A start rising edge sampled at edge N while IDLE SHALL latch len_lo1/len_hi/len_lo2/rep_cnt and enter the first non-zero phase at edge N+1.
REQ-018 Latched values SHALL be used for the whole sequence; input changes mid-burst SHALL have no effect.
REQ-019 Output during LO1 and LO2 SHALL be wave_out=0, wave_oe=1; during HI, wave_out=1, wave_oe=1.
REQ-020 Each phase SHALL last exactly its length in cycles; a length of 0 SHALL skip that phase with no dead cycle.
REQ-021 After LO2, if bursts remain, the FSM SHALL re-enter the first non-zero phase directly, with no idle cycle.
REQ-022 After the final burst, the FSM SHALL return to IDLE, and done SHALL be 1 for exactly that first IDLE cycle.
REQ-023 In IDLE, wave_out=0, wave_oe=0, busy=0.
REQ-024 All three lengths zero: no active cycle; done SHALL pulse at edge N+1; busy stays 0.
REQ-025 A start edge while busy SHALL be ignored, not queued.
REQ-026 A start held high SHALL NOT retrigger; a new burst needs 0 then 1.
REQ-027 abort=1 while busy SHALL force IDLE at the next edge, with no done.
REQ-028 If abort and a start edge coincide in IDLE, abort SHALL win and no burst starts.
REQ-029 Phase counters SHALL count down from len-1 to 0; the repeat counter SHALL count down; neither SHALL wrap.
REQ-030 Maximum length 2^CNT_W-1 and maximum repeats 2^REP_W-1 SHALL be exact.
REQ-031 Channels SHALL be fully independent; simultaneous activity on all channels is legal.

Reset
REQ-032 While rst=1 at an edge, every channel SHALL go IDLE, with wave_out=0, wave_oe=0, busy=0, done=0, and counters and start history cleared.
REQ-033 A start held high through reset release SHALL NOT trigger; the start history resets to 0 and then samples the current 1, so no edge is seen.
REQ-034 Reset mid-burst SHALL terminate the burst without a done pulse.

Structure
REQ-035 Package multi_pulse_gen_pkg SHALL hold the state enum (IDLE, LO1, HI, LO2) and the default width constants.
REQ-036 Sub-module pulse_gen_ch (one channel: edge detect, FSM, counters) SHALL be instantiated NUM_CH times by generate.
REQ-037 No logic SHALL use any clock other than clk_in; start and abort are synchronous to clk_in.

Verification
REQ-038 Ch0 lens 200/100/200, rep 0; start edge -> oe high for 500 cycles: 200 low, 100 high, 200 low; done once; busy for 500 cycles.
REQ-039 Ch1 lens 2/3/1, rep 3 -> pattern 0,0,1,1,1,0 repeated 3 times back-to-back (18 cycles), then one done.
REQ-040 Ch2 lens 0/5/0 -> 5 high cycles, no low cycles; lens 0/0/0 -> done at N+1, oe never set.
REQ-041 Ch0 lens 10/10/10: abort at cycle 15 -> IDLE at the next edge, no done; a second start at cycle 5 is ignored.
REQ-042 rst asserted at cycle 50 of a 500-cycle burst -> all outputs 0 at the next edge; start held high across reset release -> no burst.
REQ-043 All 4 channels started on the same cycle with different lengths -> each channel matches its own reference model independently.

Source files
------------

// File: rtl/multi_pulse_gen_pkg.sv
// Shared types and constants for the multi-channel burst waveform generator.
// Holds the per-channel state encoding, the default widths, and the phase
// sequencing helper that decides which phase follows a given one when some
// phases have zero length.
package multi_pulse_gen_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_REP_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO1  = 2'd1,
    HI   = 2'd2,
    LO2  = 2'd3
  } pg_state_e;

  // Next non-empty phase after 'cur' within one burst; IDLE means the burst
  // has no further phase. Calling it with cur = IDLE yields the first phase.
  function automatic pg_state_e next_phase(
    input pg_state_e cur,
    input logic      nz_lo1,
    input logic      nz_hi,
    input logic      nz_lo2
  );
    pg_state_e nxt;
    nxt = IDLE;
    case (cur)
      IDLE: begin
        if (nz_lo1)      nxt = LO1;
        else if (nz_hi)  nxt = HI;
        else if (nz_lo2) nxt = LO2;
        else             nxt = IDLE;
      end
      LO1: begin
        if (nz_hi)       nxt = HI;
        else if (nz_lo2) nxt = LO2;
        else             nxt = IDLE;
      end
      HI: begin
        if (nz_lo2)      nxt = LO2;
        else             nxt = IDLE;
      end
      LO2: begin
        nxt = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multi_pulse_gen_ch.sv
// One waveform channel: start edge detection, parameter latching, the
// IDLE/LO1/HI/LO2 sequencer with its phase and repeat down-counters, and the
// registered waveform/status outputs.
//
// Timing: a start rising edge seen at edge N latches the lengths and arms a
// launch; at edge N+1 the channel enters its first non-empty phase (or, when
// every length is zero, pulses done without ever going active).
import multi_pulse_gen_pkg::*;

module pulse_gen_ch #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int REP_W = DEF_REP_W
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] len_lo1,
  input  logic [CNT_W-1:0] len_hi,
  input  logic [CNT_W-1:0] len_lo2,
  input  logic [REP_W-1:0] rep_cnt,
  output logic             wave_out,
  output logic             wave_oe,
  output logic             busy,
  output logic             done
);

  // Length of a given phase taken from the latched burst parameters.
  function automatic logic [CNT_W-1:0] phase_len(
    input pg_state_e        st,
    input logic [CNT_W-1:0] l_lo1,
    input logic [CNT_W-1:0] l_hi,
    input logic [CNT_W-1:0] l_lo2
  );
    logic [CNT_W-1:0] len;
    len = '0;
    case (st)
      LO1:     len = l_lo1;
      HI:      len = l_hi;
      LO2:     len = l_lo2;
      default: len = '0;
    endcase
    return len;
  endfunction

  // Start history. hist_valid stays 0 for the first sample after reset so a
  // start already high at reset release is absorbed as history, not an edge.
  logic start_prev;
  logic hist_valid;
  logic rise;

  // Burst parameters captured on an accepted start edge.
  logic [CNT_W-1:0] lo1_lat;
  logic [CNT_W-1:0] hi_lat;
  logic [CNT_W-1:0] lo2_lat;
  logic             nz_lo1;
  logic             nz_hi;
  logic             nz_lo2;

  // Sequencer state.
  pg_state_e        state;
  logic             launch;
  logic [CNT_W-1:0] cnt;
  logic [REP_W-1:0] rep_left;
  logic             accept;

  // Next-state values.
  pg_state_e        nxt_state;
  pg_state_e        tgt;
  logic [CNT_W-1:0] nxt_cnt;
  logic [REP_W-1:0] nxt_rep;
  logic             nxt_done;
  logic             nxt_launch;

  // Rising-edge qualification and zero-length flags of the latched phases.
  always_comb begin
    rise   = hist_valid & start & ~start_prev;
    accept = rise & ~abort & ~launch & (state == IDLE);
    nz_lo1 = |lo1_lat;
    nz_hi  = |hi_lat;
    nz_lo2 = |lo2_lat;
  end

  // Start history register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      start_prev <= 1'b0;
      hist_valid <= 1'b0;
    end else begin
      start_prev <= start;
      hist_valid <= 1'b1;
    end
  end

  // Capture the phase lengths when a burst sequence is accepted.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      lo1_lat <= '0;
      hi_lat  <= '0;
      lo2_lat <= '0;
    end else if (accept) begin
      lo1_lat <= len_lo1;
      hi_lat  <= len_hi;
      lo2_lat <= len_lo2;
    end else begin
      lo1_lat <= lo1_lat;
      hi_lat  <= hi_lat;
      lo2_lat <= lo2_lat;
    end
  end

  // Sequencer next-state: abort first, then a pending launch, then the
  // idle edge check, then phase countdown and burst/phase advance.
  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt;
    nxt_rep    = rep_left;
    nxt_done   = 1'b0;
    nxt_launch = 1'b0;
    tgt        = IDLE;
    if (abort) begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
      nxt_rep   = '0;
    end else if (launch) begin
      tgt       = next_phase(IDLE, nz_lo1, nz_hi, nz_lo2);
      nxt_state = tgt;
      if (tgt == IDLE) begin
        nxt_done = 1'b1;
      end else begin
        nxt_cnt = phase_len(tgt, lo1_lat, hi_lat, lo2_lat) - CNT_W'(1);
      end
    end else if (state == IDLE) begin
      nxt_launch = accept;
      if (accept) begin
        // rep_left holds the bursts still to run after the current one.
        nxt_rep = (rep_cnt == '0) ? '0 : (rep_cnt - REP_W'(1));
      end else begin
        nxt_rep = rep_left;
      end
    end else if (cnt != '0) begin
      nxt_cnt = cnt - CNT_W'(1);
    end else begin
      tgt = next_phase(state, nz_lo1, nz_hi, nz_lo2);
      if (tgt != IDLE) begin
        nxt_state = tgt;
        nxt_cnt   = phase_len(tgt, lo1_lat, hi_lat, lo2_lat) - CNT_W'(1);
      end else if (rep_left != '0) begin
        // Next burst starts immediately; at least one phase is non-empty
        // because the channel is active.
        nxt_rep   = rep_left - REP_W'(1);
        tgt       = next_phase(IDLE, nz_lo1, nz_hi, nz_lo2);
        nxt_state = tgt;
        nxt_cnt   = phase_len(tgt, lo1_lat, hi_lat, lo2_lat) - CNT_W'(1);
      end else begin
        nxt_state = IDLE;
        nxt_done  = 1'b1;
      end
    end
  end

  // Sequencer registers and outputs, all driven from the next state.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= IDLE;
      launch   <= 1'b0;
      cnt      <= '0;
      rep_left <= '0;
      wave_out <= 1'b0;
      wave_oe  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= nxt_state;
      launch   <= nxt_launch;
      cnt      <= nxt_cnt;
      rep_left <= nxt_rep;
      wave_out <= (nxt_state == HI);
      wave_oe  <= (nxt_state != IDLE);
      busy     <= (nxt_state != IDLE);
      done     <= nxt_done;
    end
  end

endmodule

// File: rtl/multi_pulse_gen.sv
// Multi-channel burst waveform generator. Each channel is an independent
// pulse_gen_ch; the top only slices the packed per-channel buses.
import multi_pulse_gen_pkg::*;

module multi_pulse_gen #(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int REP_W  = DEF_REP_W
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       abort,
  input  logic [NUM_CH*CNT_W-1:0] len_lo1,
  input  logic [NUM_CH*CNT_W-1:0] len_hi,
  input  logic [NUM_CH*CNT_W-1:0] len_lo2,
  input  logic [NUM_CH*REP_W-1:0] rep_cnt,
  output logic [NUM_CH-1:0]       wave_out,
  output logic [NUM_CH-1:0]       wave_oe,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pulse_gen_ch #(
      .CNT_W (CNT_W),
      .REP_W (REP_W)
    ) u_ch (
      .clk_in   (clk_in),
      .rst      (rst),
      .start    (start[g]),
      .abort    (abort[g]),
      .len_lo1  (len_lo1[g*CNT_W +: CNT_W]),
      .len_hi   (len_hi[g*CNT_W +: CNT_W]),
      .len_lo2  (len_lo2[g*CNT_W +: CNT_W]),
      .rep_cnt  (rep_cnt[g*REP_W +: REP_W]),
      .wave_out (wave_out[g]),
      .wave_oe  (wave_oe[g]),
      .busy     (busy[g]),
      .done     (done[g])
    );
  end

endmodule
